// File: rtl/step_position_overlay.sv
// Overlays a horizontal position gauge (border, fill, marker) on a DE/HSYNC/VSYNC RGB stream.
// Two-stage pipeline; the gauge position is latched at the vsync rise so frames never tear.
module step_position_overlay #(
  parameter int unsigned HACTIVE      = 1280,
  parameter int unsigned VACTIVE      = 720,
  parameter int unsigned BAR_Y        = 600,
  parameter int unsigned BAR_H        = 32,
  parameter int unsigned POS_BITS     = 12,
  parameter int unsigned MARKER_W     = 4,
  parameter logic [23:0] BAR_COLOR    = 24'h00ff00,
  parameter logic [23:0] MARKER_COLOR = 24'hff0000,
  parameter logic [23:0] BORDER_COLOR = 24'hffffff
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [23:0]         in_data,
  input  logic                in_de,
  input  logic                in_hsync,
  input  logic                in_vsync,
  input  logic [POS_BITS-1:0] position,
  input  logic                position_valid,
  output logic [23:0]         out_data,
  output logic                out_de,
  output logic                out_hsync,
  output logic                out_vsync,
  output logic                frame_start
);

  localparam int unsigned XW = $clog2(HACTIVE);
  localparam int unsigned YW = $clog2(VACTIVE);
  localparam int unsigned PW = POS_BITS + $clog2(HACTIVE + 1);

  localparam logic [XW-1:0] XLast = XW'(HACTIVE - 1);
  localparam logic [YW-1:0] YLast = YW'(VACTIVE - 1);
  localparam logic [YW-1:0] YTop  = YW'(BAR_Y);
  localparam logic [YW-1:0] YBot  = YW'(BAR_Y + BAR_H - 1);
  localparam logic [XW:0]   MarkW = (XW + 1)'(MARKER_W);

  typedef enum logic [1:0] {ClsPass, ClsBorder, ClsMarker, ClsFill} cls_e;

  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic                locked_q, locked_d;
  logic [POS_BITS-1:0] pend_q, pend_d;
  logic [POS_BITS-1:0] disp_q, disp_d;
  logic [XW-1:0]       bar_len_q, bar_len_d;

  logic [23:0] data1_q, data2_q, data2_d;
  logic        de1_q, hs1_q, vs1_q;
  logic        de2_q, hs2_q, vs2_q;
  logic        fs_q, fs_d;
  cls_e        cls1_q, cls_d;

  logic vs_rise, de_fall, in_bar, mark_hit;

  // Stage-1 registers double as the previous-cycle copies used for edge detection.
  always_comb begin
    vs_rise = in_vsync & ~vs1_q;
    de_fall = de1_q & ~in_de;

    x_d = '0;
    if (in_de) begin
      x_d = (x_q == XLast) ? x_q : x_q + 1'b1;
    end

    y_d = y_q;
    if (vs_rise) begin
      y_d = '0;
    end else if (de_fall && (y_q != YLast)) begin
      y_d = y_q + 1'b1;
    end

    locked_d  = locked_q | vs_rise;
    pend_d    = position_valid ? position : pend_q;
    disp_d    = vs_rise ? pend_q : disp_q;
    // Full-width product, so bar_len stays within 0..HACTIVE-1.
    bar_len_d = XW'((PW'(disp_q) * PW'(HACTIVE)) >> POS_BITS);

    in_bar   = in_de & locked_q & (y_q >= YTop) & (y_q <= YBot);
    mark_hit = (x_q >= bar_len_q) && ({1'b0, x_q} < ({1'b0, bar_len_q} + MarkW));

    cls_d = ClsPass;
    if (in_bar) begin
      if ((y_q == YTop) || (y_q == YBot) || (x_q == '0) || (x_q == XLast)) begin
        cls_d = ClsBorder;
      end else if (mark_hit) begin
        cls_d = ClsMarker;
      end else if (x_q < bar_len_q) begin
        cls_d = ClsFill;
      end
    end
  end

  always_comb begin
    data2_d = data1_q;
    unique case (cls1_q)
      ClsBorder: data2_d = BORDER_COLOR;
      ClsMarker: data2_d = MARKER_COLOR;
      ClsFill:   data2_d = BAR_COLOR;
      default:   data2_d = data1_q;
    endcase
    fs_d = vs1_q & ~vs2_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      locked_q  <= 1'b0;
      pend_q    <= '0;
      disp_q    <= '0;
      bar_len_q <= '0;
      data1_q   <= '0;
      de1_q     <= 1'b0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      cls1_q    <= ClsPass;
      data2_q   <= '0;
      de2_q     <= 1'b0;
      hs2_q     <= 1'b0;
      vs2_q     <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      locked_q  <= locked_d;
      pend_q    <= pend_d;
      disp_q    <= disp_d;
      bar_len_q <= bar_len_d;
      data1_q   <= in_data;
      de1_q     <= in_de;
      hs1_q     <= in_hsync;
      vs1_q     <= in_vsync;
      cls1_q    <= cls_d;
      data2_q   <= data2_d;
      de2_q     <= de1_q;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
      fs_q      <= fs_d;
    end
  end

  assign out_data    = data2_q;
  assign out_de      = de2_q;
  assign out_hsync   = hs2_q;
  assign out_vsync   = vs2_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_step_position_overlay.sv
// Bench for step_position_overlay: frame-level reference model checked every cycle,
// plus directed gauge rows compared against hand-written colour patterns.
module tb_step_position_overlay;

  localparam int TH = 16, TV = 8, TBY = 4, TBH = 3, TPB = 4, TMW = 1;
  localparam logic [23:0] WH = 24'hffffff, GR = 24'h00ff00, RD = 24'hff0000;
  localparam logic [23:0] PASS = 24'h0000aa;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] in_data;
  logic        in_de, in_hsync, in_vsync;
  logic [3:0]  position;
  logic        position_valid;
  logic [23:0] out_data;
  logic        out_de, out_hsync, out_vsync, frame_start;

  int total = 0;
  int bad   = 0;

  step_position_overlay #(
    .HACTIVE (TH),
    .VACTIVE (TV),
    .BAR_Y   (TBY),
    .BAR_H   (TBH),
    .POS_BITS(TPB),
    .MARKER_W(TMW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .in_data       (in_data),
    .in_de         (in_de),
    .in_hsync      (in_hsync),
    .in_vsync      (in_vsync),
    .position      (position),
    .position_valid(position_valid),
    .out_data      (out_data),
    .out_de        (out_de),
    .out_hsync     (out_hsync),
    .out_vsync     (out_vsync),
    .frame_start   (frame_start)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_x, m_y, m_pend, m_disp, m_len, ln;
  bit m_lk, m_pvs, m_pde, vr, df, chk_en;
  logic [23:0] pix, s1_data, e_data;
  logic s1_de, s1_hs, s1_vs, e_de, e_hs, e_vs, e_fs;

  function automatic logic [23:0] overlay(int x, int y, int len, logic [23:0] d, logic de, bit lk);
    if (!(de && lk && y >= TBY && y < TBY + TBH)) return d;
    if (y == TBY || y == TBY + TBH - 1 || x == 0 || x == TH - 1) return WH;
    if (x >= len && x < len + TMW) return RD;
    if (x < len) return GR;
    return d;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_x = 0; m_y = 0; m_pend = 0; m_disp = 0; m_len = 0;
      m_lk = 0; m_pvs = 0; m_pde = 0;
      s1_data = '0; s1_de = 0; s1_hs = 0; s1_vs = 0;
      e_data = '0; e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0;
    end else begin
      vr  = in_vsync && !m_pvs;
      df  = m_pde && !in_de;
      pix = overlay(m_x, m_y, m_len, in_data, in_de, m_lk);
      e_fs = s1_vs && !e_vs;
      e_data = s1_data; e_de = s1_de; e_hs = s1_hs; e_vs = s1_vs;
      s1_data = pix; s1_de = in_de; s1_hs = in_hsync; s1_vs = in_vsync;
      ln = (m_disp * TH) >> TPB;
      if (vr) m_disp = m_pend;
      if (position_valid) m_pend = int'(position);
      m_len = ln;
      if (vr) m_lk = 1;
      m_x = in_de ? ((m_x < TH - 1) ? m_x + 1 : m_x) : 0;
      if (vr) m_y = 0;
      else if (df && m_y < TV - 1) m_y = m_y + 1;
      m_pvs = in_vsync;
      m_pde = in_de;
    end
    chk_en = 1;
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("out_data", out_data, e_data);
      check("out_de", 24'(out_de), 24'(e_de));
      check("out_hsync", 24'(out_hsync), 24'(e_hs));
      check("out_vsync", 24'(out_vsync), 24'(e_vs));
      check("frame_start", 24'(frame_start), 24'(e_fs));
    end
  end

  // ---------------- output-side capture ----------------
  int ox = 0, oy = 0, nonpass = 0, nde = 0;
  logic pov = 0, pod = 0;
  logic [23:0] pass_val = '0;
  logic [23:0] cap[TV][TH];
  logic [23:0] mcap[TV][TH];

  always @(negedge clock) begin
    if (out_vsync && !pov) begin
      oy = 0; ox = 0;
    end
    if (out_de) begin
      if (ox < TH && oy < TV) begin
        cap[oy][ox]  = out_data;
        mcap[oy][ox] = e_data;
      end
      ox++;
      nde++;
      if (out_data !== pass_val) nonpass++;
    end else if (pod) begin
      oy++; ox = 0;
    end
    pov = out_vsync;
    pod = out_de;
  end

  // ---------------- stimulus ----------------
  logic [23:0] fix_data = PASS;

  task automatic cyc(input logic de, input logic hs, input logic vs, input logic [23:0] d,
                     input logic pv, input logic [3:0] pos);
    in_de = de; in_hsync = hs; in_vsync = vs; in_data = d;
    position_valid = pv; position = pos;
    @(negedge clock);
  endtask

  task automatic frame(input bit rnd, input bit novs, input int pv_line, input logic [3:0] pv_val,
                       input bit vs_pv, input logic [3:0] vs_val, input int rst_line);
    int len;
    bit pv;
    logic [3:0] pos;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, !novs, '0, vs_pv && i == 0, vs_val);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    for (int l = 0; l < TV; l++) begin
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      len = rnd ? $urandom_range(13, 19) : TH;
      for (int p = 0; p < len; p++) begin
        pv  = (l == pv_line && p == 3) || (rnd && $urandom_range(0, 40) == 0);
        pos = (l == pv_line && p == 3) ? pv_val : 4'($urandom);
        if (l == rst_line && p == 6) reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, rnd ? 24'($urandom) : fix_data, pv, pos);
        if (reset) begin
          reset = 1'b0;
          check("rst_mid_data", out_data, 24'h0);
          check("rst_mid_de", 24'(out_de), 24'h0);
          check("rst_mid_fs", 24'(frame_start), 24'h0);
          nonpass = 0;
        end
      end
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    end
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic check_row5(input string nm, input int mk);
    logic [23:0] ev;
    for (int x = 0; x < TH; x++) begin
      if (x == 0 || x == TH - 1) ev = WH;
      else if (x < mk) ev = GR;
      else if (x == mk) ev = RD;
      else ev = PASS;
      check(nm, cap[5][x], ev);
      check({nm, "_model"}, mcap[5][x], ev);
    end
  endtask

  task automatic check_row_white(input string nm, input int row);
    for (int x = 0; x < TH; x++) check(nm, cap[row][x], WH);
  endtask

  int nde0;
  bit vs_state;

  initial begin
    reset = 1'b1;
    in_data = '0; in_de = 0; in_hsync = 0; in_vsync = 0; position = '0; position_valid = 0;
    repeat (3) @(negedge clock);
    check("reset_data", out_data, 24'h0);
    check("reset_de", 24'(out_de), 24'h0);
    check("reset_hs", 24'(out_hsync), 24'h0);
    check("reset_vs", 24'(out_vsync), 24'h0);
    check("reset_fs", 24'(frame_start), 24'h0);

    reset = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 24'h123456, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, 24'h123456, 1'b0, '0);
    check("prelock_data", out_data, 24'h123456);
    check("prelock_de", 24'(out_de), 24'h1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);

    fix_data = 24'h123456; pass_val = 24'h123456; nonpass = 0; nde0 = nde;
    frame(0, 1, -1, '0, 0, '0, -1);
    check("prelock_overlay", 24'(nonpass), 24'h0);
    check("prelock_pixels", 24'(nde - nde0), 24'(TH * TV));

    fix_data = PASS; pass_val = PASS;
    frame(0, 0, 2, 4'd8, 0, '0, -1);
    check_row5("cur_frame", 0);
    frame(0, 0, 2, 4'd15, 0, '0, -1);
    check_row5("mid8", 8);
    check_row_white("mid8_top", 4);
    check_row_white("mid8_bot", 6);
    frame(0, 0, 2, 4'd0, 0, '0, -1);
    check_row5("max15", 15);
    frame(0, 0, 2, 4'd3, 0, '0, -1);
    check_row5("zero", 0);
    frame(0, 0, -1, '0, 1, 4'd10, -1);
    check_row5("coinc", 3);
    frame(0, 0, -1, '0, 0, '0, -1);
    check_row5("coinc_next", 10);
    frame(0, 0, 2, 4'd9, 0, '0, 5);
    check("rst_passthru", 24'(nonpass), 24'h0);
    frame(0, 0, -1, '0, 0, '0, -1);
    check_row5("after_rst", 0);

    for (int f = 0; f < 12; f++) frame(1, 0, $urandom_range(0, 9), 4'($urandom), 0, '0, -1);

    vs_state = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 30) == 0) vs_state = !vs_state;
      if ($urandom_range(0, 300) == 0) reset = 1'b1;
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), vs_state, 24'($urandom),
          1'($urandom_range(0, 19) == 0), 4'($urandom));
      reset = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
